// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS-Lite pipeline hazard controller:
// opcode encodings, controller state enum and source-operand usage decode.
package mips_pkg;

   localparam int OPC_W_C = 6;

   localparam logic [OPC_W_C-1:0] OP_ADD  = 6'd0;
   localparam logic [OPC_W_C-1:0] OP_ADDI = 6'd1;
   localparam logic [OPC_W_C-1:0] OP_SUB  = 6'd2;
   localparam logic [OPC_W_C-1:0] OP_SUBI = 6'd3;
   localparam logic [OPC_W_C-1:0] OP_MUL  = 6'd4;
   localparam logic [OPC_W_C-1:0] OP_MULI = 6'd5;
   localparam logic [OPC_W_C-1:0] OP_OR   = 6'd6;
   localparam logic [OPC_W_C-1:0] OP_ORI  = 6'd7;
   localparam logic [OPC_W_C-1:0] OP_AND  = 6'd8;
   localparam logic [OPC_W_C-1:0] OP_ANDI = 6'd9;
   localparam logic [OPC_W_C-1:0] OP_XOR  = 6'd10;
   localparam logic [OPC_W_C-1:0] OP_XORI = 6'd11;
   localparam logic [OPC_W_C-1:0] OP_LDW  = 6'd12;
   localparam logic [OPC_W_C-1:0] OP_STW  = 6'd13;
   localparam logic [OPC_W_C-1:0] OP_BZ   = 6'd14;
   localparam logic [OPC_W_C-1:0] OP_BEQ  = 6'd15;
   localparam logic [OPC_W_C-1:0] OP_JMP  = 6'd16;
   localparam logic [OPC_W_C-1:0] OP_HLT  = 6'd17;

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      DRAIN  = 2'd1,
      HALTED = 2'd2
   } hctrl_state_e;

   function automatic logic uses_rs(input logic [OPC_W_C-1:0] op);
      logic r;
      case (op)
         OP_ADD, OP_ADDI, OP_SUB, OP_SUBI, OP_MUL, OP_MULI,
         OP_OR, OP_ORI, OP_AND, OP_ANDI, OP_XOR, OP_XORI,
         OP_LDW, OP_STW, OP_BZ, OP_BEQ: r = 1'b1;
         default:                       r = 1'b0;
      endcase
      return r;
   endfunction

   function automatic logic uses_rt(input logic [OPC_W_C-1:0] op);
      logic r;
      case (op)
         OP_ADD, OP_SUB, OP_MUL, OP_OR, OP_AND, OP_XOR,
         OP_STW, OP_BEQ: r = 1'b1;
         default:        r = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/mips_sat_counter.sv
// Statistics counter that sticks at all-ones instead of wrapping.
// clear is synchronous and has priority over inc.
module mips_sat_counter #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             clear,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // next value: clear, saturating increment, or hold
   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = {CNT_W{1'b0}};
      end else if (inc && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         cnt_d = cnt_q;
      end
   end

   // count register
   always_ff @(posedge clk) begin
      cnt_q <= cnt_d;
   end

   assign count = cnt_q;

endmodule

// File: rtl/mips_pipe_hazard_ctrl.sv
// MIPS-Lite pipeline controller: RAW stall, taken-branch flush, HLT drain, statistics.
// Optional macro MIPS_HAZ_FORWARD_EN: load-use-only stalls plus fwd_a_sel/fwd_b_sel outputs.
module mips_pipe_hazard_ctrl
   import mips_pkg::*;
#(
   parameter int OPC_W        = 6,
   parameter int REG_IDX_W    = 5,
   parameter int CNT_W        = 32,
   parameter int DRAIN_CYCLES = 3
) (
   input  logic                 CLOCK,
   input  logic                 RESET_N,
   input  logic                 id_valid,
   input  logic [OPC_W-1:0]     id_opcode,
   input  logic [REG_IDX_W-1:0] id_rs,
   input  logic [REG_IDX_W-1:0] id_rt,
   input  logic                 ex_wr,
   input  logic [REG_IDX_W-1:0] ex_dest,
   input  logic                 ex_is_load,
   input  logic                 mem_wr,
   input  logic [REG_IDX_W-1:0] mem_dest,
   input  logic                 ex_br_taken,
   output logic                 stall_if,
   output logic                 stall_id,
   output logic                 flush_ifid,
   output logic                 flush_idex,
   output logic                 pc_sel_branch,
   output logic                 halted,
   output logic [CNT_W-1:0]     stall_cnt,
   output logic [CNT_W-1:0]     branch_cnt
`ifdef MIPS_HAZ_FORWARD_EN
   ,
   output logic [1:0]           fwd_a_sel,
   output logic [1:0]           fwd_b_sel
`endif
);

   localparam int DRN_W = $clog2(DRAIN_CYCLES + 1);

   hctrl_state_e     state_q, state_d;
   logic [DRN_W-1:0] drain_q, drain_d;

   logic rs_used, rt_used;
   logic ex_hit_rs, ex_hit_rt, mem_hit_rs, mem_hit_rt;
   logic hazard;
   logic stall_inc, branch_inc;

   assign rs_used    = uses_rs(id_opcode);
   assign rt_used    = uses_rt(id_opcode);
   assign ex_hit_rs  = ex_wr  && (ex_dest  == id_rs);
   assign ex_hit_rt  = ex_wr  && (ex_dest  == id_rt);
   assign mem_hit_rs = mem_wr && (mem_dest == id_rs);
   assign mem_hit_rt = mem_wr && (mem_dest == id_rt);

`ifdef MIPS_HAZ_FORWARD_EN
   // with forwarding only a load result still in EX cannot be bypassed in time
   assign hazard = id_valid && ex_is_load &&
                   ((rs_used && ex_hit_rs) || (rt_used && ex_hit_rt));

   // bypass select per operand, the younger EX result wins over MEM
   always_comb begin
      fwd_a_sel = 2'b00;
      fwd_b_sel = 2'b00;
      if (RESET_N && id_valid) begin
         if (rs_used && ex_hit_rs) begin
            fwd_a_sel = 2'b01;
         end else if (rs_used && mem_hit_rs) begin
            fwd_a_sel = 2'b10;
         end else begin
            fwd_a_sel = 2'b00;
         end
         if (rt_used && ex_hit_rt) begin
            fwd_b_sel = 2'b01;
         end else if (rt_used && mem_hit_rt) begin
            fwd_b_sel = 2'b10;
         end else begin
            fwd_b_sel = 2'b00;
         end
      end else begin
         fwd_a_sel = 2'b00;
         fwd_b_sel = 2'b00;
      end
   end
`else
   logic unused_load_flag;
   assign unused_load_flag = ex_is_load;

   assign hazard = id_valid &&
                   ((rs_used && (ex_hit_rs || mem_hit_rs)) ||
                    (rt_used && (ex_hit_rt || mem_hit_rt)));
`endif

   // controller next state and same-cycle pipeline control
   always_comb begin
      state_d       = state_q;
      drain_d       = drain_q;
      stall_if      = 1'b0;
      stall_id      = 1'b0;
      flush_ifid    = 1'b0;
      flush_idex    = 1'b0;
      pc_sel_branch = 1'b0;
      halted        = 1'b0;
      stall_inc     = 1'b0;
      branch_inc    = 1'b0;
      if (!RESET_N) begin
         state_d = RUN;
         drain_d = {DRN_W{1'b0}};
      end else begin
         case (state_q)
            RUN: begin
               if (ex_br_taken) begin
                  flush_ifid    = 1'b1;
                  flush_idex    = 1'b1;
                  pc_sel_branch = 1'b1;
                  branch_inc    = 1'b1;
               end else if (hazard) begin
                  stall_if  = 1'b1;
                  stall_id  = 1'b1;
                  stall_inc = 1'b1;
               end else if (id_valid && (id_opcode == OP_HLT)) begin
                  state_d = DRAIN;
                  drain_d = {DRN_W{1'b0}};
               end else begin
                  state_d = RUN;
               end
            end
            DRAIN: begin
               // a branch right behind HLT means the HLT itself was wrong-path
               if ((drain_q == {DRN_W{1'b0}}) && ex_br_taken) begin
                  flush_ifid    = 1'b1;
                  flush_idex    = 1'b1;
                  pc_sel_branch = 1'b1;
                  branch_inc    = 1'b1;
                  state_d       = RUN;
                  drain_d       = {DRN_W{1'b0}};
               end else if (drain_q == DRN_W'(DRAIN_CYCLES - 1)) begin
                  stall_if = 1'b1;
                  state_d  = HALTED;
                  drain_d  = {DRN_W{1'b0}};
               end else begin
                  stall_if = 1'b1;
                  drain_d  = drain_q + {{(DRN_W-1){1'b0}}, 1'b1};
               end
            end
            HALTED: begin
               stall_if = 1'b1;
               halted   = 1'b1;
            end
            default: begin
               state_d = RUN;
               drain_d = {DRN_W{1'b0}};
            end
         endcase
      end
   end

   // controller state registers with synchronous reset
   always_ff @(posedge CLOCK) begin
      if (!RESET_N) begin
         state_q <= RUN;
         drain_q <= {DRN_W{1'b0}};
      end else begin
         state_q <= state_d;
         drain_q <= drain_d;
      end
   end

   mips_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
      .clk   (CLOCK),
      .clear (!RESET_N),
      .inc   (stall_inc),
      .count (stall_cnt)
   );

   mips_sat_counter #(.CNT_W(CNT_W)) u_branch_cnt (
      .clk   (CLOCK),
      .clear (!RESET_N),
      .inc   (branch_inc),
      .count (branch_cnt)
   );

endmodule
